// File: rtl/tl_ram_slave_pkg.sv
// Shared TileLink-UL constants and the response record for tl_ram_slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: bus widths, A/D opcodes, the TL_RAM_SLAVE_CHECK_EN build flag, and the tl_resp_t record.
package tl_ram_slave_pkg;

  localparam int TL_DATA_BYTES    = 4;
  localparam int TL_LG_DATA_BYTES = 2;
  localparam int TL_SIZE_BITS     = 3;
  localparam int TL_SOURCE_BITS   = 4;
  localparam int TL_SINK_BITS     = 1;
  localparam int TL_ADDR_BITS     = 32;

  localparam logic [2:0] TL_A_PUTFULL       = 3'd0;
  localparam logic [2:0] TL_A_PUTPARTIAL    = 3'd1;
  localparam logic [2:0] TL_A_GET           = 3'd4;
  localparam logic [2:0] TL_D_ACCESSACK     = 3'd0;
  localparam logic [2:0] TL_D_ACCESSACKDATA = 3'd1;

  // Mirrors the request-checking build macro so that other code can query the build.
`ifdef TL_RAM_SLAVE_CHECK_EN
  localparam bit TL_RAM_SLAVE_CHECK = 1'b1;
`else
  localparam bit TL_RAM_SLAVE_CHECK = 1'b0;
`endif

  // One entry of the D-channel response queue.
  typedef struct packed {
    logic [2:0]                  opcode;
    logic [TL_SIZE_BITS-1:0]     size;
    logic [TL_SOURCE_BITS-1:0]   source;
    logic                        denied;
    logic [TL_DATA_BYTES*8-1:0]  data;
  } tl_resp_t;

endpackage

// File: rtl/tl_ram_slave_if.sv
// TileLink-UL A/D channel bundle between the adapter master and the RAM slave.
// Latency: n/a (wires only).
// Backpressure: a_ready is driven by the slave; d_ready is driven by the master.
// Modports: master drives A and d_ready; slave drives D and a_ready.
interface tl_ram_slave_if;
  import tl_ram_slave_pkg::*;

  logic                         a_valid;
  logic                         a_ready;
  logic [2:0]                   a_opcode;
  logic [2:0]                   a_param;
  logic [TL_SIZE_BITS-1:0]      a_size;
  logic [TL_SOURCE_BITS-1:0]    a_source;
  logic [TL_ADDR_BITS-1:0]      a_address;
  logic [TL_DATA_BYTES-1:0]     a_mask;
  logic [TL_DATA_BYTES*8-1:0]   a_data;

  logic                         d_valid;
  logic                         d_ready;
  logic [2:0]                   d_opcode;
  logic [1:0]                   d_param;
  logic [TL_SIZE_BITS-1:0]      d_size;
  logic [TL_SOURCE_BITS-1:0]    d_source;
  logic [TL_SINK_BITS-1:0]      d_sink;
  logic                         d_denied;
  logic [TL_DATA_BYTES*8-1:0]   d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data
  );

endinterface

// File: rtl/tl_resp_fifo.sv
// Synchronous circular FIFO holding D-channel responses.
// Latency: a pushed entry is visible at head_dat on the following cycle.
// Backpressure: a push while full and a pop while empty are ignored; the caller throttles on count.
// Ports: clk, rst (sync, active-high), push/push_dat, pop, head_dat, count.
module tl_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // DEPTH need not be a power of two, so the pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_push  = push && (int'(count_q) < DEPTH);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/tl_ram_slave.sv
// TileLink-UL slave answering Get/PutFullData/PutPartialData from an on-chip word RAM.
// Latency: an A handshake in cycle N produces d_valid in cycle N+2 when the queue is empty.
// Backpressure: a_ready drops once queued plus in-flight responses reach RESP_DEPTH, independent of d_ready.
// Ports: clk, rst (sync, active-high), tl (tl_ram_slave_if.slave). Build macro TL_RAM_SLAVE_CHECK_EN
// enables address/size/alignment/opcode checking with denied responses.
module tl_ram_slave
  import tl_ram_slave_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RESP_DEPTH  = 3
) (
  input logic           clk,
  input logic           rst,
  tl_ram_slave_if.slave tl
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int DW    = TL_DATA_BYTES * 8;

  logic [IDX_W-1:0]          a_idx;
  logic                      a_hs;
  logic                      req_is_put, req_is_get, req_denied, req_rdata;
  logic                      ram_we, rd_en;
  logic                      unused_bits;

  logic                      s1_valid_q, s1_valid_d;
  logic [2:0]                s1_opcode_q, s1_opcode_d;
  logic [TL_SIZE_BITS-1:0]   s1_size_q, s1_size_d;
  logic [TL_SOURCE_BITS-1:0] s1_source_q, s1_source_d;
  logic                      s1_denied_q, s1_denied_d;
  logic                      s1_rdata_q, s1_rdata_d;

  logic [DW-1:0]             ram_q [DEPTH_WORDS];
  logic [DW-1:0]             rd_data_q;

  tl_resp_t                  push_dat, head_dat;
  logic [CNT_W-1:0]          q_count;
  logic                      d_pop;

  assign a_idx       = tl.a_address[TL_LG_DATA_BYTES +: IDX_W];
  // Counts the response still in s1 so a full queue can never be overrun.
  assign tl.a_ready  = !rst && ((int'(q_count) + int'(s1_valid_q)) < RESP_DEPTH);
  assign a_hs        = tl.a_valid && tl.a_ready;
  // Address bits outside the word index only matter to the checker; a_param is ignored.
  assign unused_bits = ^{tl.a_param, tl.a_address[TL_ADDR_BITS-1:TL_LG_DATA_BYTES+IDX_W],
                         tl.a_address[TL_LG_DATA_BYTES-1:0]};

  always_comb begin
    req_is_put = (tl.a_opcode == TL_A_PUTFULL) || (tl.a_opcode == TL_A_PUTPARTIAL);
    req_is_get = (tl.a_opcode == TL_A_GET);
`ifdef TL_RAM_SLAVE_CHECK_EN
    req_denied = (tl.a_address[TL_ADDR_BITS-1:TL_LG_DATA_BYTES+IDX_W] != '0)
              || (tl.a_size > TL_SIZE_BITS'(TL_LG_DATA_BYTES))
              || ((tl.a_address[7:0] & ((8'd1 << tl.a_size) - 8'd1)) != 8'd0)
              || !(req_is_put || req_is_get);
    req_rdata  = req_is_get;
`else
    // Unchecked build: the index slice wraps the address, unknown opcodes read like a Get.
    req_denied = 1'b0;
    req_rdata  = !req_is_put;
`endif
    ram_we = a_hs && req_is_put && !req_denied;
    rd_en  = a_hs && req_rdata && !req_denied;
  end

  always_comb begin
    s1_valid_d  = a_hs;
    s1_opcode_d = s1_opcode_q;
    s1_size_d   = s1_size_q;
    s1_source_d = s1_source_q;
    s1_denied_d = s1_denied_q;
    s1_rdata_d  = s1_rdata_q;
    if (a_hs) begin
      s1_opcode_d = req_rdata ? TL_D_ACCESSACKDATA : TL_D_ACCESSACK;
      s1_size_d   = tl.a_size;
      s1_source_d = tl.a_source;
      s1_denied_d = req_denied;
      s1_rdata_d  = req_rdata && !req_denied;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_opcode_q <= '0;
      s1_size_q   <= '0;
      s1_source_q <= '0;
      s1_denied_q <= 1'b0;
      s1_rdata_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opcode_q <= s1_opcode_d;
      s1_size_q   <= s1_size_d;
      s1_source_q <= s1_source_d;
      s1_denied_q <= s1_denied_d;
      s1_rdata_q  <= s1_rdata_d;
    end
  end

  // RAM is never reset; the byte-masked write and the read land on separate edges
  // for back-to-back Put/Get, so the Get observes the new data.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < TL_DATA_BYTES; b++) begin
        if (tl.a_mask[b]) ram_q[a_idx][b*8 +: 8] <= tl.a_data[b*8 +: 8];
      end
    end
    if (rd_en) rd_data_q <= ram_q[a_idx];
  end

  always_comb begin
    push_dat.opcode = s1_opcode_q;
    push_dat.size   = s1_size_q;
    push_dat.source = s1_source_q;
    push_dat.denied = s1_denied_q;
    push_dat.data   = s1_rdata_q ? rd_data_q : '0;
  end

  assign d_pop = tl.d_valid && tl.d_ready;

  tl_resp_fifo #(
    .WIDTH ($bits(tl_resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (s1_valid_q),
    .push_dat (push_dat),
    .pop      (d_pop),
    .head_dat (head_dat),
    .count    (q_count)
  );

  // D fields are forced to zero whenever the queue is empty.
  always_comb begin
    tl.d_valid  = (q_count != '0);
    tl.d_param  = '0;
    tl.d_sink   = '0;
    tl.d_opcode = '0;
    tl.d_size   = '0;
    tl.d_source = '0;
    tl.d_denied = 1'b0;
    tl.d_data   = '0;
    if (tl.d_valid) begin
      tl.d_opcode = head_dat.opcode;
      tl.d_size   = head_dat.size;
      tl.d_source = head_dat.source;
      tl.d_denied = head_dat.denied;
      tl.d_data   = head_dat.data;
    end
  end

endmodule
